// File: rtl/cpu_mem_pkg.sv
// Shared CPU memory-subsystem definitions: bus widths, arbiter FSM states and
// transaction owner encodings used by the fetch, load/store and arbiter blocks.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } mem_arb_state_t;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester (fetch, load/store) and memory-port signals around the
// arbiter; slave is the arbiter side, master is the CPU/memory side.
interface mem_bus_arbiter_if
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_picker.sv
// Combinational winner select: data has priority unless fetch is starved.
module mem_arb_picker
  import cpu_mem_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic starved,
  output logic pick_valid,
  output logic pick_owner
);

  // NOTE: every output gets a default before the branches, so no latch can be inferred.
  always_comb begin
    pick_valid = f_req | d_req;
    pick_owner = OWNER_FETCH;
    if (d_req && !(f_req && starved)) begin
      pick_owner = OWNER_DATA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one
// transaction in flight, with a starvation counter guaranteeing fetch progress.
module mem_bus_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int LAT_W = 3;

  mem_arb_state_t    state, state_next;
  logic              owner;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] f_rdata_q, d_rdata_q;
  logic [3:0]        starve_cnt;
  logic [LAT_W-1:0]  lat_cnt;

  logic pick_valid, pick_owner, grant, capture;

  mem_arb_picker u_picker (
    .f_req      (bus.f_req),
    .d_req      (bus.d_req),
    .starved    (starve_cnt == 4'(STARVE_MAX)),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  // Grants exist only in IDLE and are forced low while reset is held.
  assign grant   = (state == IDLE) && pick_valid && !rst;
  assign capture = (state == WAIT) && (lat_cnt == LAT_W'(1));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_valid) state_next = ACCESS;
      ACCESS:  state_next = WAIT;
      WAIT:    if (lat_cnt == LAT_W'(1)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments and the async reset clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWNER_FETCH;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
      starve_cnt <= '0;
      lat_cnt    <= '0;
    end else begin
      state <= state_next;

      if (grant) begin
        owner   <= pick_owner;
        addr_q  <= (pick_owner == OWNER_DATA) ? bus.d_addr : bus.f_addr;
        we_q    <= (pick_owner == OWNER_DATA) && bus.d_we;
        wdata_q <= (pick_owner == OWNER_DATA) ? bus.d_wdata : '0;
        if (pick_owner == OWNER_FETCH || !bus.f_req) begin
          starve_cnt <= '0;
        end else if (starve_cnt != 4'(STARVE_MAX)) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end

      // WAIT spans MEM_LAT cycles; the last one carries valid mem_rdata.
      if (state == ACCESS) begin
        lat_cnt <= LAT_W'(MEM_LAT);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end

      if (capture) begin
        if (owner == OWNER_FETCH) f_rdata_q <= we_q ? '0 : bus.mem_rdata;
        else                      d_rdata_q <= we_q ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.f_gnt     = grant && (pick_owner == OWNER_FETCH);
  assign bus.d_gnt     = grant && (pick_owner == OWNER_DATA);
  assign bus.f_rvalid  = (state == RESP) && (owner == OWNER_FETCH);
  assign bus.d_rvalid  = (state == RESP) && (owner == OWNER_DATA);
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = (state == ACCESS);
  assign bus.mem_we    = (state == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table-driven single/dual transactions on a
// MEM_LAT=1 instance plus starvation, in-flight, latency-4 and reset sequences.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus4 ();

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(4), .STARVE_MAX(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // Memory model: read data is driven only in the cycle MEM_LAT after mem_en.
  logic [7:0] mem [256];
  int         cyc = 0;
  int         rd_due = -1, rd_due4 = -1;
  logic [7:0] rd_val = 8'h00, rd_val4 = 8'h00;
  int         d_rv4_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else begin
        rd_due <= cyc + 1;
        rd_val <= mem[bus.mem_addr];
      end
    end
    if (bus4.mem_en && !bus4.mem_we) begin
      rd_due4 <= cyc + 4;
      rd_val4 <= mem[bus4.mem_addr];
    end
    if (bus4.d_rvalid) d_rv4_cnt <= d_rv4_cnt + 1;
  end

  assign bus.mem_rdata  = (cyc == rd_due)  ? rd_val  : 8'hEE;
  assign bus4.mem_rdata = (cyc == rd_due4) ? rd_val4 : 8'hEE;

  int checks = 0;
  int failures = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       f_req;
    logic       d_req;
    logic       d_we;
    logic [7:0] f_addr;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       exp_f_gnt;
    logic       exp_d_gnt;
    logic [7:0] exp_addr;
    logic       exp_we;
    logic [7:0] exp_rdata;
    logic [7:0] exp2_rdata;
  } vec_t;

  vec_t vecs [6];

  // Runs ACCESS, WAIT and RESP of a MEM_LAT=1 transaction granted in the previous cycle.
  task automatic serve(input string tag, input logic data, input logic [7:0] addr,
                       input logic we, input logic [7:0] wdata, input logic [7:0] rdata);
    @(negedge clk);
    if (data) bus.d_req = 1'b0;
    else      bus.f_req = 1'b0;
    #1;
    check1({tag, "_mem_en"}, bus.mem_en, 1'b1);
    check8({tag, "_mem_addr"}, bus.mem_addr, addr);
    check1({tag, "_mem_we"}, bus.mem_we, we);
    if (we) check8({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
    check1({tag, "_no_gnt_access"}, bus.f_gnt | bus.d_gnt, 1'b0);
    @(negedge clk); #1;
    check1({tag, "_mem_en_wait"}, bus.mem_en, 1'b0);
    check1({tag, "_busy_wait"}, bus.busy, 1'b1);
    @(negedge clk); #1;
    check1({tag, "_f_rvalid"}, bus.f_rvalid, !data);
    check1({tag, "_d_rvalid"}, bus.d_rvalid, data);
    check8({tag, "_rdata"}, data ? bus.d_rdata : bus.f_rdata, rdata);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    bus.f_req   = v.f_req;
    bus.f_addr  = v.f_addr;
    bus.d_req   = v.d_req;
    bus.d_we    = v.d_we;
    bus.d_addr  = v.d_addr;
    bus.d_wdata = v.d_wdata;
    #1;
    check1({tag, "_f_gnt"}, bus.f_gnt, v.exp_f_gnt);
    check1({tag, "_d_gnt"}, bus.d_gnt, v.exp_d_gnt);
    check1({tag, "_busy_idle"}, bus.busy, 1'b0);
    serve(tag, v.exp_d_gnt, v.exp_addr, v.exp_we, v.d_wdata, v.exp_rdata);
    if (v.f_req && v.d_req) begin
      @(negedge clk); #1;
      check1({tag, "_f_gnt2"}, bus.f_gnt, 1'b1);
      check1({tag, "_d_gnt2"}, bus.d_gnt, 1'b0);
      serve({tag, "b"}, 1'b0, v.f_addr, 1'b0, 8'h00, v.exp2_rdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_cnt;
    logic       exp_f;
    int         d_rv4_before;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'hA5;
    mem[8'h05] = 8'h77;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h20, 8'h3C, 1'b0, 1'b1, 8'h20, 1'b1, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h20, 8'h00, 1'b0, 1'b1, 8'h20, 1'b0, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h30, 8'h40, 8'h00, 1'b0, 1'b1, 8'h40, 1'b0, 8'h1A, 8'h6A};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h50, 8'h81, 1'b0, 1'b1, 8'h50, 1'b1, 8'h00, 8'h4B};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h50, 8'h00, 8'h00, 1'b1, 1'b0, 8'h50, 1'b0, 8'h81, 8'h00};

    bus.f_req = 1'b0; bus.f_addr = 8'h00; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
    bus4.f_req = 1'b0; bus4.f_addr = 8'h00; bus4.d_req = 1'b0; bus4.d_we = 1'b0;
    bus4.d_addr = 8'h00; bus4.d_wdata = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_mem_en", bus.mem_en, 1'b0);
    check8("rst_mem_addr", bus.mem_addr, 8'h00);
    check1("rst_f_rvalid", bus.f_rvalid, 1'b0);
    check8("rst_f_rdata", bus.f_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Continuous dual traffic: D,D,D,F repeating with starve_cnt tracking
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 8'h70;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h60;
    exp_cnt = 8'h00;
    for (int i = 0; i < 8; i++) begin
      exp_f = (i % 4 == 3);
      if (i > 0) @(negedge clk);
      #1;
      check1($sformatf("st%0d_f_gnt", i), bus.f_gnt, exp_f);
      check1($sformatf("st%0d_d_gnt", i), bus.d_gnt, !exp_f);
      @(negedge clk);
      if (exp_f) bus.f_req = 1'b0;
      else       bus.d_req = 1'b0;
      exp_cnt = exp_f ? 8'h00 : exp_cnt + 8'h01;
      #1;
      check8($sformatf("st%0d_starve_cnt", i), {4'h0, dut.starve_cnt}, exp_cnt);
      @(negedge clk);
      @(negedge clk); #1;
      check1($sformatf("st%0d_rvalid", i), exp_f ? bus.f_rvalid : bus.d_rvalid, 1'b1);
      check8($sformatf("st%0d_rdata", i), exp_f ? bus.f_rdata : bus.d_rdata,
             exp_f ? 8'h2A : 8'h3A);
      bus.f_req = 1'b1;
      bus.d_req = 1'b1;
    end
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;

    // Data request arriving during an in-flight fetch
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 8'h10;
    #1;
    check1("fl_f_gnt", bus.f_gnt, 1'b1);
    @(negedge clk);
    bus.f_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h40;
    #1;
    check1("fl_d_gnt_access", bus.d_gnt, 1'b0);
    check8("fl_mem_addr_f", bus.mem_addr, 8'h10);
    @(negedge clk); #1;
    check1("fl_d_gnt_wait", bus.d_gnt, 1'b0);
    @(negedge clk); #1;
    check1("fl_d_gnt_resp", bus.d_gnt, 1'b0);
    check1("fl_f_rvalid", bus.f_rvalid, 1'b1);
    check8("fl_f_rdata", bus.f_rdata, 8'hA5);
    @(negedge clk); #1;
    check1("fl_d_gnt_idle", bus.d_gnt, 1'b1);
    serve("fl_d", 1'b1, 8'h40, 1'b0, 8'h00, 8'h1A);
    check8("fl_f_rdata_hold", bus.f_rdata, 8'hA5);

    // MEM_LAT = 4 load timing
    @(negedge clk);
    bus4.d_req = 1'b1; bus4.d_we = 1'b0; bus4.d_addr = 8'h05;
    #1;
    check1("l4_d_gnt", bus4.d_gnt, 1'b1);
    check1("l4_busy_t0", bus4.busy, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus4.d_req = 1'b0;
      #1;
      check1($sformatf("l4_busy_t%0d", k), bus4.busy, 1'b1);
      check1($sformatf("l4_mem_en_t%0d", k), bus4.mem_en, k == 1);
      check1($sformatf("l4_d_rvalid_t%0d", k), bus4.d_rvalid, k == 6);
      if (k == 6) check8("l4_d_rdata", bus4.d_rdata, 8'h77);
    end
    @(negedge clk); #1;
    check1("l4_busy_t7", bus4.busy, 1'b0);

    // Reset during WAIT drops the load; pending fetch wins the first IDLE
    d_rv4_before = d_rv4_cnt;
    @(negedge clk);
    bus4.d_req = 1'b1; bus4.d_we = 1'b0; bus4.d_addr = 8'h05;
    #1;
    check1("rw_d_gnt", bus4.d_gnt, 1'b1);
    @(negedge clk);
    bus4.d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus4.f_req = 1'b1; bus4.f_addr = 8'h10;
    rst = 1'b1;
    #1;
    check1("rw_busy", bus4.busy, 1'b0);
    check1("rw_mem_en", bus4.mem_en, 1'b0);
    check8("rw_mem_addr", bus4.mem_addr, 8'h00);
    check1("rw_f_gnt", bus4.f_gnt, 1'b0);
    check1("rw_d_rvalid", bus4.d_rvalid, 1'b0);
    check8("rw_d_rdata", bus4.d_rdata, 8'h00);
    check1("rw_main_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check1("rw_f_gnt_first_idle", bus4.f_gnt, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus4.f_req = 1'b0;
      #1;
      check1($sformatf("rw_mem_en_t%0d", k), bus4.mem_en, k == 1);
      check1($sformatf("rw_f_rvalid_t%0d", k), bus4.f_rvalid, k == 6);
      if (k == 1) check8("rw_mem_addr_f", bus4.mem_addr, 8'h10);
      if (k == 6) check8("rw_f_rdata", bus4.f_rdata, 8'hA5);
    end
    @(negedge clk);
    check8("rw_no_dropped_rvalid", 8'(d_rv4_cnt), 8'(d_rv4_before));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
